skid_stage: RTL and testbench
=============================

Name: skid_stage

Overview:
- Two-entry ready/valid pipeline stage (skid buffer) that sits directly upstream of an enable-register stage.
- Converts a producer's valid/ready stream into a registered output whose data and valid are driven straight from flops.
- Decouples upstream ready timing from downstream backpressure.
- Full throughput: 1 word/cycle, 1-cycle latency when empty.

Parameters:
WIDTH, 8, data word width in bits (>=1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset, sampled on rising clk
in_valid  input  1  producer has a word on in_data
in_ready  output  1  stage accepts a word this cycle
in_data  input  WIDTH  producer data
out_valid  output  1  out_data holds a valid word
out_ready  input  1  consumer accepts out_data this cycle
out_data  output  WIDTH  registered output word

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Handshake events:
  - in_fire = in_valid && in_ready.
  - out_fire = out_valid && out_ready.
  - A transfer happens only on a rising clk edge where the fire term is 1.
- Storage:
  - main register drives out_data directly.
  - skid register holds one overflow word.
  - No combinational path from in_data to out_data.
- State (2-bit enum):
  - EMPTY: main invalid, skid invalid.
  - BUSY: main valid, skid invalid.
  - FULL: main valid, skid valid.
- Outputs:
  - out_valid = (state != EMPTY).
  - in_ready = !reset && (state != FULL).
  - in_ready depends only on state and reset, never on out_ready, so there is no ready combinational path.
- Transitions on rising clk when reset=0:
  - EMPTY, in_fire: main<=in_data, go to BUSY.
  - EMPTY, no in_fire: stay.
  - BUSY, in_fire && out_fire: main<=in_data, stay BUSY.
  - BUSY, in_fire only: skid<=in_data, go to FULL.
  - BUSY, out_fire only: go to EMPTY.
  - BUSY, neither: hold.
  - FULL, out_fire: main<=skid, go to BUSY.
  - FULL, no out_fire: hold. in_ready=0, so no input is accepted.
- Reset (reset=1 at rising edge):
  - state<=EMPTY, main<=0, skid<=0, overriding every other event.
  - While reset=1, in_ready=0. After the first reset edge, out_valid=0 and out_data=0.
  - Reset mid-transfer drops both buffered words silently; any fire in that cycle is discarded.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold unchanged.
- Ordering: words leave in acceptance order. No loss, no duplication.
- out_data in EMPTY: holds the last value (0 after reset). Consumers ignore it because out_valid=0.
- Latency: a word accepted at edge N is visible on out_data after edge N when the stage was EMPTY, or BUSY with out_fire.
- Throughput: sustained 1 word/cycle while out_ready=1.
- Width rule: all data paths exactly WIDTH bits. No arithmetic.

Decomposition:
- Shared package (pipe_pkg): skid_state_t enum {EMPTY, BUSY, FULL} and its 2-bit encoding constant.
- One natural sub-module, skid_slot (WIDTH parameter): a clk-edge register with load enable and synchronous active-high clear, instantiated twice (main, skid).
- FSM and handshake logic stay in skid_stage.

Test Plan:
- Reset check: reset=1 for 2 cycles with in_valid=1, in_data=8'hAA -> in_ready=0 during reset; after release out_valid=0, out_data=0, in_ready=1, and 8'hAA is never emitted.
- Pass-through: out_ready=1, send 8'd1,2,3 on consecutive cycles -> out_data shows 1,2,3 on the following cycles, out_valid=1 each cycle, in_ready stays 1.
- Backpressure fill:
  - out_ready=0, send 8'd42 then 8'd17 -> after 2 edges state FULL, in_ready=0, out_data=42 held.
  - A third word 8'd99 offered with in_valid=1 is not accepted.
- Drain: from that FULL state set out_ready=1 -> out_data=42, then 17 on the next edge, then 99 once accepted; out_valid deasserts after the last word. Exact order 42,17,99.
- Simultaneous: BUSY holding 8'd5, in_valid=1 with 8'd6 and out_ready=1 in the same cycle -> state stays BUSY, out_data=6, skid unused.
- Reset mid-operation: FULL holding 42/17, assert reset for 1 cycle with out_ready=1 -> out_valid=0, out_data=0; neither 42 nor 17 appears afterwards.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the skid pipeline stage.
package pipe_pkg;

    localparam int unsigned SKID_STATE_W = 2;

    typedef enum logic [SKID_STATE_W-1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/skid_slot.sv
// One data register with load enable and synchronous clear.
module skid_slot #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/skid_stage.sv
// Two-entry ready/valid skid buffer; out_data comes straight from the main register.
module skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_t      state;
    skid_state_t      state_next;
    logic             in_fire;
    logic             out_fire;
    logic             main_load;
    logic             main_from_skid;
    logic             skid_load;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next state and register load controls.
    always_comb begin
        state_next     = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    main_load  = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_load = 1'b1;
                end else if (in_fire) begin
                    skid_load  = 1'b1;
                    state_next = FULL;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    state_next     = BUSY;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // Handshake outputs depend only on state and reset.
    always_comb begin
        out_valid = 1'b0;
        in_ready  = 1'b0;
        out_valid = (state != EMPTY);
        in_ready  = !reset && (state != FULL);
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    skid_slot #(.WIDTH(WIDTH)) u_main (
        .clk   (clk),
        .clear (reset),
        .load  (main_load),
        .d     (main_d),
        .q     (out_data)
    );

    skid_slot #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .clear (reset),
        .load  (skid_load),
        .d     (in_data),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_skid_stage.sv
// Bench for skid_stage: directed scenarios plus random traffic against a queue model.
module tb_skid_stage;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    int unsigned n_checks;
    int unsigned n_pass;

    logic [WIDTH-1:0] fifo[$];
    logic [WIDTH-1:0] last_head;
    bit               model_known;

    skid_stage #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle, check outputs against the queue model, then advance the model.
    task automatic cycle(input logic r, input logic iv, input logic [WIDTH-1:0] d,
                         input logic ordy);
        bit in_acc;
        bit out_acc;
        reset     = r;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        if (r) begin
            check("in_ready_rst", 32'(in_ready), 32'd0);
        end else if (model_known) begin
            check("in_ready", 32'(in_ready), 32'(fifo.size() < 2));
        end
        if (model_known) begin
            check("out_valid", 32'(out_valid), 32'(fifo.size() > 0));
            check("out_data", 32'(out_data), 32'(fifo.size() > 0 ? fifo[0] : last_head));
        end
        @(posedge clk);
        if (r) begin
            fifo.delete();
            last_head   = '0;
            model_known = 1'b1;
        end else begin
            in_acc  = iv && (fifo.size() < 2);
            out_acc = ordy && (fifo.size() > 0);
            if (out_acc) void'(fifo.pop_front());
            if (in_acc) fifo.push_back(d);
            if (fifo.size() > 0) last_head = fifo[0];
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        model_known = 1'b0;
        last_head   = '0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        @(negedge clk);

        // Reset with a word offered that must never appear.
        cycle(1'b1, 1'b1, 8'hAA, 1'b0);
        cycle(1'b1, 1'b1, 8'hAA, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Pass-through at full rate.
        cycle(1'b0, 1'b1, 8'd1, 1'b1);
        cycle(1'b0, 1'b1, 8'd2, 1'b1);
        cycle(1'b0, 1'b1, 8'd3, 1'b1);
        cycle(1'b0, 1'b0, 8'd0, 1'b1);
        cycle(1'b0, 1'b0, 8'd0, 1'b1);

        // Backpressure fill, rejected third word, then drain.
        cycle(1'b0, 1'b1, 8'd42, 1'b0);
        cycle(1'b0, 1'b1, 8'd17, 1'b0);
        cycle(1'b0, 1'b1, 8'd99, 1'b0);
        cycle(1'b0, 1'b1, 8'd99, 1'b0);
        cycle(1'b0, 1'b1, 8'd99, 1'b1);
        cycle(1'b0, 1'b1, 8'd99, 1'b1);
        cycle(1'b0, 1'b0, 8'd0, 1'b1);
        cycle(1'b0, 1'b0, 8'd0, 1'b1);
        cycle(1'b0, 1'b0, 8'd0, 1'b1);

        // Simultaneous accept and emit while holding one word.
        cycle(1'b0, 1'b1, 8'd5, 1'b0);
        cycle(1'b0, 1'b1, 8'd6, 1'b1);
        cycle(1'b0, 1'b0, 8'd0, 1'b0);
        cycle(1'b0, 1'b0, 8'd0, 1'b1);

        // Reset while full drops both words.
        cycle(1'b0, 1'b1, 8'd42, 1'b0);
        cycle(1'b0, 1'b1, 8'd17, 1'b0);
        cycle(1'b1, 1'b0, 8'd0, 1'b1);
        cycle(1'b0, 1'b0, 8'd0, 1'b1);
        cycle(1'b0, 1'b0, 8'd0, 1'b1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 3) != 0),
                  WIDTH'($urandom),
                  1'($urandom_range(0, 2) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
